// File: rtl/l3_pkg.sv
// Shared definitions for the layer-3 response path: default field widths,
// response head encodings and the packed response entry layout.
package l3_pkg;

  localparam int L3_ERR_W = 2;
  localparam int L3_RES_W = 4;
  localparam int HEAD_W   = 2;

  // Head bit 1 flags an interface ID error, bit 0 an interface ready error.
  localparam logic [HEAD_W-1:0] HEAD_NONE = 2'b00;
  localparam logic [HEAD_W-1:0] HEAD_RDY  = 2'b01;
  localparam logic [HEAD_W-1:0] HEAD_ID   = 2'b10;
  localparam logic [HEAD_W-1:0] HEAD_BOTH = 2'b11;

  typedef struct packed {
    logic [HEAD_W-1:0]   head;
    logic [L3_ERR_W-1:0] err;
    logic [L3_RES_W-1:0] res;
  } l3_resp_t;

endpackage

// File: rtl/l3_resp_fifo.sv
// Generic synchronous show-ahead FIFO. Fullness and emptiness come from an
// explicit level counter, so the pointers can simply wrap. Only control state
// is reset; storage contents are left as they are.
module l3_resp_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_pop_ok  = i_pop & ~o_empty & ~i_flush;
  // A pop in the same cycle frees the slot a push needs when full.
  assign w_push_ok = i_push & ~i_flush & (~o_full | w_pop_ok);

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage write; not reset, only ever read behind a valid level.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and level bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/l3_resp_q.sv
// Layer-3 core response queue. Interface-error and response-done events are
// merged into one {head, err, res} entry per cycle and queued, so bursts are
// not lost while the core is busy. The head entry is offered on a valid/ready
// port; a sticky flag records any event dropped because the queue was full.
module l3_resp_q
  import l3_pkg::*;
#(
  parameter  int ERR_W = L3_ERR_W,
  parameter  int RES_W = L3_RES_W,
  parameter  int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_core,
  input  logic                      l3_en,
  input  logic                      core_sel,
  input  logic                      err_if_id,
  input  logic                      err_if_rdy,
  input  logic                      resp_done,
  input  logic [ERR_W-1:0]          resp_err,
  input  logic [RES_W-1:0]          resp_res,
  input  logic                      resp_rdy,
  output logic [HEAD_W+ERR_W+RES_W-1:0] core_resp,
  output logic                      core_resp_vld,
  output logic [LVL_W-1:0]          resp_level,
  output logic                      resp_ovf
);

  localparam int ENT_W = HEAD_W + ERR_W + RES_W;

  logic             w_flush;
  logic             w_evt;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_head_data;
  logic             r_ovf;

  // Starting a new transaction discards everything queued for the old one.
  assign w_flush = clr_core | (core_sel & l3_en);
  assign w_evt   = err_if_id | err_if_rdy | resp_done;

  // Error and done events in the same cycle share a single entry.
  assign w_entry = {err_if_id, err_if_rdy,
                    resp_done ? resp_err : {ERR_W{1'b0}},
                    resp_done ? resp_res : {RES_W{1'b0}}};

  assign w_pop  = ~w_empty & resp_rdy;
  assign w_push = w_evt & ~w_flush & (~w_full | w_pop);
  assign w_drop = w_evt & ~w_flush & w_full & ~w_pop;

  l3_resp_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_entry),
    .o_rdata (w_head_data),
    .o_level (resp_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky overflow: set by a dropped event, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_flush) r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
  end

  // Outputs derive from registered level and storage only; stale storage is masked.
  assign core_resp_vld = ~w_empty;
  assign core_resp     = core_resp_vld ? w_head_data : '0;
  assign resp_ovf      = r_ovf;

endmodule
